// File: rtl/calc_1.sv
// calc_1: four independent two-cycle add/subtract/shift channels with registered one-cycle responses.
// Optional shifter enabled by defining CALC_1_SHIFT_EN; otherwise commands 5 and 6 respond as invalid.
module calc_1 (
    output logic [0:31] out_data1,
    output logic [0:31] out_data2,
    output logic [0:31] out_data3,
    output logic [0:31] out_data4,
    output logic [0:1]  out_resp1,
    output logic [0:1]  out_resp2,
    output logic [0:1]  out_resp3,
    output logic [0:1]  out_resp4,
    input  logic        c_clk,
    input  logic [0:3]  req1_cmd_in,
    input  logic [0:31] req1_data_in,
    input  logic [0:3]  req2_cmd_in,
    input  logic [0:31] req2_data_in,
    input  logic [0:3]  req3_cmd_in,
    input  logic [0:31] req3_data_in,
    input  logic [0:3]  req4_cmd_in,
    input  logic [0:31] req4_data_in,
    input  logic [1:7]  reset
);

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
`ifdef CALC_1_SHIFT_EN
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;
`endif

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    // Any asserted reset bit resets the whole block.
    logic rst;
    assign rst = |reset;

    logic [3:0]  cmd_in [4];
    logic [31:0] din    [4];
    logic [31:0] dout   [4];
    logic [1:0]  rout   [4];

    assign cmd_in[0] = req1_cmd_in;
    assign cmd_in[1] = req2_cmd_in;
    assign cmd_in[2] = req3_cmd_in;
    assign cmd_in[3] = req4_cmd_in;
    assign din[0]    = req1_data_in;
    assign din[1]    = req2_data_in;
    assign din[2]    = req3_data_in;
    assign din[3]    = req4_data_in;

    // Returns {resp, data}; data is forced to zero whenever resp is not success.
    function automatic logic [33:0] compute(input logic [3:0]  cmd,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] sum;
        logic [33:0] r;
`ifdef CALC_1_SHIFT_EN
        logic [4:0]  sh;
        sh = b[4:0];
`endif
        r   = {RESP_ERR, 32'd0};
        sum = {1'b0, a} + {1'b0, b};
        case (cmd)
            CMD_ADD: if (!sum[32]) r = {RESP_OK, sum[31:0]};
            CMD_SUB: if (b <= a)   r = {RESP_OK, a - b};
`ifdef CALC_1_SHIFT_EN
            CMD_SHL: r = {RESP_OK, a << sh};
            CMD_SHR: r = {RESP_OK, a >> sh};
`endif
            default: r = {RESP_ERR, 32'd0};
        endcase
        return r;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_ch
        logic        busy_q, busy_d;
        logic [3:0]  cmd_q, cmd_d;
        logic [31:0] op1_q, op1_d;
        logic [31:0] data_q, data_d;
        logic [1:0]  resp_q, resp_d;

        // Idle: sample a command with operand 1. Busy: take operand 2 and respond.
        always_comb begin
            busy_d = busy_q;
            cmd_d  = cmd_q;
            op1_d  = op1_q;
            data_d = 32'd0;
            resp_d = RESP_NONE;
            if (busy_q) begin
                busy_d           = 1'b0;
                {resp_d, data_d} = compute(cmd_q, op1_q, din[g]);
            end else if (cmd_in[g] != CMD_NOP) begin
                busy_d = 1'b1;
                cmd_d  = cmd_in[g];
                op1_d  = din[g];
            end
        end

        always_ff @(posedge c_clk) begin
            if (rst) begin
                busy_q <= 1'b0;
                data_q <= 32'd0;
                resp_q <= RESP_NONE;
            end else begin
                busy_q <= busy_d;
                data_q <= data_d;
                resp_q <= resp_d;
            end
            cmd_q <= cmd_d;
            op1_q <= op1_d;
        end

        assign dout[g] = data_q;
        assign rout[g] = resp_q;
    end

    assign out_data1 = dout[0];
    assign out_data2 = dout[1];
    assign out_data3 = dout[2];
    assign out_data4 = dout[3];
    assign out_resp1 = rout[0];
    assign out_resp2 = rout[1];
    assign out_resp3 = rout[2];
    assign out_resp4 = rout[3];

endmodule

// File: tb/tb_calc_1.sv
// Directed table-driven bench for calc_1; shift expectations follow CALC_1_SHIFT_EN.
module tb_calc_1;

    logic        c_clk = 1'b0;
    logic [1:7]  reset;
    logic [0:3]  cmd  [4];
    logic [0:31] din  [4];
    logic [0:31] od   [4];
    logic [0:1]  orsp [4];

    int errors = 0;
    int checks = 0;

`ifdef CALC_1_SHIFT_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    always #5 c_clk = ~c_clk;

    calc_1 dut (
        .out_data1(od[0]), .out_data2(od[1]), .out_data3(od[2]), .out_data4(od[3]),
        .out_resp1(orsp[0]), .out_resp2(orsp[1]), .out_resp3(orsp[2]), .out_resp4(orsp[3]),
        .c_clk(c_clk),
        .req1_cmd_in(cmd[0]), .req1_data_in(din[0]),
        .req2_cmd_in(cmd[1]), .req2_data_in(din[1]),
        .req3_cmd_in(cmd[2]), .req3_data_in(din[2]),
        .req4_cmd_in(cmd[3]), .req4_data_in(din[3]),
        .reset(reset)
    );

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  resp;
        logic [31:0] data;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                input logic [1:0] r, input logic [31:0] d);
        vec_t v;
        v.c = c; v.a = a; v.b = b; v.resp = r; v.data = d;
        return v;
    endfunction

    // Shift vectors expect success only when the shifter is built in.
    function automatic vec_t mksh(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] d);
        return SH ? mk(c, a, b, 2'd1, d) : mk(c, a, b, 2'd2, 32'd0);
    endfunction

    task automatic chk(input string name, input int p, input logic [1:0] er, input logic [31:0] ed);
        logic [31:0] ad;
        logic [1:0]  ar;
        ad = od[p];
        ar = orsp[p];
        checks++;
        if (ar !== er || ad !== ed) begin
            errors++;
            $display("FAIL %s port%0d: got resp=%0d data=%h, want resp=%0d data=%h",
                     name, p + 1, ar, ad, er, ed);
        end
    endtask

    task automatic chk_all_zero(input string name);
        for (int p = 0; p < 4; p++) chk(name, p, 2'd0, 32'd0);
    endtask

    // E1 carries cmd/op1, E2 carries op2; response sampled just after E2.
    task automatic do_op(input string name, input int p, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] er, input logic [31:0] ed);
        @(negedge c_clk);
        cmd[p] = c;
        din[p] = a;
        @(negedge c_clk);
        cmd[p] = 4'd0;
        din[p] = b;
        @(posedge c_clk);
        #1;
        chk(name, p, er, ed);
    endtask

    task automatic idle_cycle(input string name);
        @(negedge c_clk);
        for (int p = 0; p < 4; p++) begin cmd[p] = 4'd0; din[p] = 32'd0; end
        @(posedge c_clk);
        #1;
        chk_all_zero(name);
    endtask

    initial begin
        logic [31:0] x;

        tbl[0]  = mk(4'd1, 32'h00000001, 32'h1FFFFFFF, 2'd1, 32'h20000000);
        tbl[1]  = mk(4'd1, 32'h1FFFFFFF, 32'h1FFFFFFF, 2'd1, 32'h3FFFFFFE);
        tbl[2]  = mk(4'd1, 32'h00000000, 32'h00000000, 2'd1, 32'h00000000);
        tbl[3]  = mk(4'd1, 32'hFFFFFFFF, 32'h00000001, 2'd2, 32'h00000000);
        tbl[4]  = mk(4'd2, 32'h00000001, 32'h0000000F, 2'd2, 32'h00000000);
        tbl[5]  = mk(4'd2, 32'h0000000F, 32'h00000001, 2'd1, 32'h0000000E);
        tbl[6]  = mk(4'd3, 32'h12345678, 32'h00000001, 2'd2, 32'h00000000);
        tbl[7]  = mk(4'd4, 32'h00000001, 32'h00000001, 2'd2, 32'h00000000);
        tbl[8]  = mk(4'd7, 32'h00000005, 32'h00000003, 2'd2, 32'h00000000);
        tbl[9]  = mk(4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd2, 32'h00000000);
        tbl[10] = mk(4'd1, 32'h80000000, 32'h80000000, 2'd2, 32'h00000000);
        tbl[11] = mk(4'd1, 32'h7FFFFFFF, 32'h80000000, 2'd1, 32'hFFFFFFFF);
        tbl[12] = mk(4'd2, 32'h00000005, 32'h00000005, 2'd1, 32'h00000000);
        tbl[13] = mk(4'd2, 32'hFFFFFFFF, 32'h00000000, 2'd1, 32'hFFFFFFFF);
        tbl[14] = mksh(4'd5, 32'h12345678, 32'h00000004, 32'h23456780);
        tbl[15] = mksh(4'd6, 32'h12345678, 32'h00000004, 32'h01234567);
        tbl[16] = mksh(4'd5, 32'hA5A5A5A5, 32'h00000000, 32'hA5A5A5A5);
        tbl[17] = mksh(4'd5, 32'hF0000001, 32'hFFFFFFE4, 32'h00000010);
        tbl[18] = mksh(4'd6, 32'h80000000, 32'h0000001F, 32'h00000001);

        for (int p = 0; p < 4; p++) begin cmd[p] = 4'd0; din[p] = 32'd0; end
        reset = 7'b1111111;
        @(posedge c_clk); #1;
        chk_all_zero("reset_all");
        reset = 7'b1000000;
        @(posedge c_clk); #1;
        chk_all_zero("reset_bit1");
        @(negedge c_clk);
        reset = 7'b0000000;

        idle_cycle("nop_idle");

        // Table applied on port1, then rotated over all ports.
        for (int i = 0; i < 19; i++)
            do_op($sformatf("tbl%0d", i), 0, tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].resp, tbl[i].data);
        idle_cycle("after_b2b");
        for (int i = 0; i < 19; i++)
            do_op($sformatf("rot%0d", i), i % 4, tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].resp, tbl[i].data);
        idle_cycle("after_rot");

        // Walking one.
        for (int k = 0; k <= 30; k++) begin
            x = 32'h1 << k;
            do_op($sformatf("walk_add%0d", k), 0, 4'd1, x, 32'd0, 2'd1, x);
            do_op($sformatf("walk_shl%0d", k), 0, 4'd5, x, 32'd1,
                  SH ? 2'd1 : 2'd2, SH ? (x << 1) : 32'd0);
        end
        idle_cycle("after_walk");

        // Operand-2 cycle with a nonzero cmd must not start a new operation.
        @(negedge c_clk); cmd[1] = 4'd1; din[1] = 32'h00000010;
        @(negedge c_clk); cmd[1] = 4'd2; din[1] = 32'h00000020;
        @(posedge c_clk); #1; chk("cmd_ignored_e2", 1, 2'd1, 32'h00000030);
        @(negedge c_clk); cmd[1] = 4'd0; din[1] = 32'd0;
        @(posedge c_clk); #1; chk("cmd_ignored_e3", 1, 2'd0, 32'd0);

        // Four simultaneous adds.
        @(negedge c_clk);
        for (int p = 0; p < 4; p++) begin cmd[p] = 4'd1; din[p] = 32'h100 * (p + 1); end
        @(negedge c_clk);
        for (int p = 0; p < 4; p++) begin cmd[p] = 4'd0; din[p] = p + 1; end
        @(posedge c_clk); #1;
        for (int p = 0; p < 4; p++)
            chk("par_add", p, 2'd1, 32'h100 * (p + 1) + p + 1);
        idle_cycle("par_e3");

        // Reset between E1 and E2 aborts with no response.
        @(negedge c_clk); cmd[0] = 4'd1; din[0] = 32'h5; cmd[2] = 4'd2; din[2] = 32'h9;
        @(negedge c_clk); cmd[0] = 4'd0; din[0] = 32'h6; cmd[2] = 4'd0; din[2] = 32'h1;
        reset = 7'b1000000;
        @(posedge c_clk); #1; chk_all_zero("rst_abort");
        @(negedge c_clk); reset = 7'b0000000; din[0] = 32'h0; din[2] = 32'h0;
        @(posedge c_clk); #1; chk_all_zero("rst_abort_after");

        // Reset wins over a command at the same edge; port idle afterwards.
        @(negedge c_clk); reset = 7'b0000001; cmd[3] = 4'd1; din[3] = 32'h7;
        @(posedge c_clk); #1; chk("rst_prio", 3, 2'd0, 32'd0);
        @(negedge c_clk); reset = 7'b0000000; cmd[3] = 4'd0; din[3] = 32'h8;
        @(posedge c_clk); #1; chk("rst_prio_idle", 3, 2'd0, 32'd0);
        do_op("post_rst_op", 3, 4'd2, 32'h10, 32'h3, 2'd1, 32'hD);
        idle_cycle("final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
